data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 87 ++++++++
 tb/tb_data_memory.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: byte-addressed big-endian data memory with power-up clear sweep
// Ports: clk, i_rst_n (async active-low); i_req/i_we/i_size/i_unsigned/i_addr/i_data request;
//        o_data/o_valid registered load result, o_ready accept, o_misalign reject pulse.
// Optional macro DMEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_req,
  input  logic               i_we,
  input  logic [1:0]         i_size,
  input  logic               i_unsigned,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_ready,
  output logic               o_misalign
);
  localparam int CW = NB_ADDR > 2 ? NB_ADDR - 2 : 1;
  localparam logic [CW-1:0] LAST = CW'(2**NB_ADDR / 4 - 1);
  typedef enum logic {CLEAR, IDLE} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic [7:0] mem_q [2**NB_ADDR];
  logic [NB_ADDR-1:0] base;
  logic [NB_ADDR-1:0] la [4];
  logic [7:0] rb [4];
  logic [7:0] wd [4];
  logic [3:0] wen;
  logic [31:0] st_word, ld_word, ld;
  logic acc, mis, sx;
  assign o_ready = state_q == IDLE;
  assign acc = o_ready & i_req;
  assign o_data = data_q;
  assign o_valid = valid_q;
`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  assign mis = (i_size == 2'b01 & i_addr[0]) | (i_size[1] & |i_addr[1:0]);
  assign o_misalign = mis_q;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) mis_q <= 1'b0;
    else mis_q <= acc & mis;
`else
  assign mis = 1'b0;
  assign o_misalign = 1'b0;
`endif
  // Four byte lanes at base+k; the CLEAR sweep reuses them to zero one word per cycle.
  always_comb begin
    base = state_q == CLEAR ? NB_ADDR'({cnt_q, 2'b00}) : i_addr;
    st_word = i_size[1] ? i_data : i_size[0] ? {i_data[15:0], 16'h0} : {i_data[7:0], 24'h0};
    sx = ~i_unsigned;
    for (int k = 0; k < 4; k++) begin
      la[k] = base + NB_ADDR'(k);
      rb[k] = mem_q[la[k]];
      wd[k] = state_q == CLEAR ? 8'h00 : st_word[8*(3-k) +: 8];
    end
    wen = state_q == CLEAR ? 4'hf
        : (acc & i_we & ~mis) ? (i_size[1] ? 4'hf : i_size[0] ? 4'h3 : 4'h1) : 4'h0;
    ld_word = {rb[0], rb[1], rb[2], rb[3]};
    ld = i_size[1] ? ld_word
       : i_size[0] ? {{16{sx & rb[0][7]}}, rb[0], rb[1]} : {{24{sx & rb[0][7]}}, rb[0]};
    valid_d = acc & ~i_we;
    data_d = valid_d ? (mis ? '0 : ld) : data_q;
    state_d = (state_q == CLEAR && cnt_q == LAST) ? IDLE : state_q;
    cnt_d = state_q == CLEAR ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (wen[k]) mem_q[la[k]] <= wd[k];
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized self-checking bench for data_memory against a byte-array model
module tb_data_memory;
  logic clk = 0, i_rst_n = 0, i_req = 0, i_we = 0, i_unsigned = 0;
  logic [1:0] i_size = 0;
  logic [7:0] i_addr = 0;
  logic [31:0] i_data = 0;
  logic [31:0] o_data;
  logic o_valid, o_ready, o_misalign;
  int errors = 0, checks = 0;
  logic [7:0] ref_mem [256];
  logic [31:0] exp_data = 0;
  logic [31:0] got;
  int n;

  always #5 clk = ~clk;

  data_memory #(.NB_DATA(32), .NB_ADDR(8)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_addr(i_addr), .i_data(i_data), .o_data(o_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_misalign(o_misalign)
  );

  function automatic logic is_mis(input logic [1:0] sz, input logic [7:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [7:0] a);
    logic [31:0] v = 0;
    int cnt = nbytes(sz);
    for (int k = 0; k < cnt; k++) v = (v << 8) | 32'(ref_mem[8'(a + k)]);
    if (!uns && cnt < 4 && v[8*cnt-1]) v = v | (32'hFFFFFFFF << (8 * cnt));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    int cnt = nbytes(sz);
    for (int k = 0; k < cnt; k++) ref_mem[8'(a + k)] = 8'(d >> (8 * (cnt - 1 - k)));
  endtask

  task automatic ref_clear();
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
    exp_data = 0;
  endtask

  task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [7:0] a, input logic [31:0] d, output logic [31:0] g);
    logic m;
    @(negedge clk);
    i_req = 1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = a; i_data = d;
    @(posedge clk); #1;
    i_req = 0;
    m = is_mis(sz, a);
    if (!we) exp_data = m ? 32'h0 : ref_load(sz, uns, a);
    else if (!m) ref_store(sz, a, d);
    checks++;
    if (o_valid !== !we) begin errors++; $display("FAIL valid addr=%h we=%b got=%b want=%b", a, we, o_valid, !we); end
    checks++;
    if (o_data !== exp_data) begin errors++; $display("FAIL data addr=%h sz=%0d uns=%b we=%b got=%h want=%h", a, sz, uns, we, o_data, exp_data); end
    checks++;
    if (o_misalign !== m) begin errors++; $display("FAIL misalign addr=%h sz=%0d got=%b want=%b", a, sz, o_misalign, m); end
    g = o_data;
  endtask

  task automatic idle();
    @(negedge clk);
    i_req = 0;
    @(posedge clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_misalign !== 1'b0 || o_data !== exp_data) begin
      errors++; $display("FAIL idle valid=%b mis=%b data=%h want data=%h", o_valid, o_misalign, o_data, exp_data);
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      checks++;
      if (o_valid !== 1'b0 || o_misalign !== 1'b0) begin
        errors++; $display("FAIL clear_outputs cycle=%0d valid=%b mis=%b want 0 0", cyc, o_valid, o_misalign);
      end
      if (o_ready === 1'b1) break;
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (o_data !== 32'h0 || o_valid !== 1'b0 || o_misalign !== 1'b0 || o_ready !== 1'b0) begin
      errors++; $display("FAIL %s data=%h valid=%b mis=%b ready=%b want all 0", tag, o_data, o_valid, o_misalign, o_ready);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 0;
    #23;
    check_zero("reset_state");
  endtask

  task automatic test_clear();
    @(negedge clk);
    i_rst_n = 1;
    wait_ready(n);
    checks++;
    if (n !== 64) begin errors++; $display("FAIL clear_length got=%0d want=64", n); end
    ref_clear();
    access(0, 2'd2, 0, 8'h00, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL first_load got=%h want=00000000", got); end
  endtask

  task automatic test_spec_vectors();
    access(1, 2'd2, 0, 8'h10, 32'h8899AABC, got);
    access(0, 2'd0, 0, 8'h13, 0, got);
    checks++;
    if (got !== 32'hFFFFFFBC) begin errors++; $display("FAIL byte_signed got=%h want=FFFFFFBC", got); end
    access(0, 2'd1, 1, 8'h10, 0, got);
    checks++;
    if (got !== 32'h00008899) begin errors++; $display("FAIL half_unsigned got=%h want=00008899", got); end
    access(0, 2'd1, 0, 8'h10, 0, got);
    checks++;
    if (got !== 32'hFFFF8899) begin errors++; $display("FAIL half_signed got=%h want=FFFF8899", got); end
    access(0, 2'd0, 1, 8'h11, 0, got);
    checks++;
    if (got !== 32'h00000099) begin errors++; $display("FAIL byte_unsigned got=%h want=00000099", got); end
    access(0, 2'd3, 1, 8'h10, 0, got);
    checks++;
    if (got !== 32'h8899AABC) begin errors++; $display("FAIL size3_word got=%h want=8899AABC", got); end
  endtask

  task automatic test_back_to_back();
    access(1, 2'd2, 0, 8'h40, 32'h01234567, got);
    access(0, 2'd2, 0, 8'h40, 0, got);
    checks++;
    if (got !== 32'h01234567) begin errors++; $display("FAIL raw_word got=%h want=01234567", got); end
    access(1, 2'd0, 0, 8'h41, 32'h000000F0, got);
    access(0, 2'd1, 1, 8'h40, 0, got);
    checks++;
    if (got !== 32'h000001F0) begin errors++; $display("FAIL raw_byte got=%h want=000001F0", got); end
    access(1, 2'd1, 0, 8'h42, 32'h0000BEEF, got);
    for (int k = 0; k < 4; k++) access(0, 2'd0, 0, 8'(8'h40 + k), 0, got);
    idle();
    access(1, 2'd2, 0, 8'h44, 32'h5A5A5A5A, got);
    idle();
  endtask

  task automatic test_wrap_align();
`ifdef DMEM_ALIGN_CHECK_EN
    access(1, 2'd2, 0, 8'h20, 32'hCAFEF00D, got);
    access(1, 2'd2, 0, 8'h24, 32'h00000000, got);
    access(1, 2'd2, 0, 8'h21, 32'hFFFFFFFF, got);
    access(0, 2'd2, 0, 8'h20, 0, got);
    checks++;
    if (got !== 32'hCAFEF00D) begin errors++; $display("FAIL misaligned_store_wrote got=%h want=CAFEF00D", got); end
    access(0, 2'd1, 0, 8'h23, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL misaligned_load got=%h want=00000000", got); end
    access(1, 2'd1, 0, 8'h26, 32'h0000FFFF, got);
    idle();
`else
    access(1, 2'd2, 0, 8'hFE, 32'h11223344, got);
    access(0, 2'd0, 1, 8'hFE, 0, got);
    checks++;
    if (got !== 32'h11) begin errors++; $display("FAIL wrap_FE got=%h want=00000011", got); end
    access(0, 2'd0, 1, 8'hFF, 0, got);
    checks++;
    if (got !== 32'h22) begin errors++; $display("FAIL wrap_FF got=%h want=00000022", got); end
    access(0, 2'd0, 1, 8'h00, 0, got);
    checks++;
    if (got !== 32'h33) begin errors++; $display("FAIL wrap_00 got=%h want=00000033", got); end
    access(0, 2'd0, 1, 8'h01, 0, got);
    checks++;
    if (got !== 32'h44) begin errors++; $display("FAIL wrap_01 got=%h want=00000044", got); end
    access(0, 2'd2, 0, 8'h23, 0, got);
`endif
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else begin
        a = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
        access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, got);
      end
    end
  endtask

  task automatic test_reset_mid();
    access(1, 2'd2, 0, 8'h10, 32'hDEADBEEF, got);
    access(0, 2'd2, 0, 8'h10, 0, got);
    @(posedge clk); #2;
    i_rst_n = 0;
    #1;
    check_zero("reset_mid_access");
    @(negedge clk);
    i_rst_n = 1;
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (o_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b want=0", o_ready); end
    end
    #1;
    i_rst_n = 0;
    #1;
    check_zero("reset_mid_clear");
    i_req = 1; i_we = 1; i_size = 2'd2; i_addr = 8'h04; i_data = 32'hFFFFFFFF;
    @(negedge clk);
    i_rst_n = 1;
    wait_ready(n);
    i_req = 0;
    checks++;
    if (n !== 64) begin errors++; $display("FAIL reclear_length got=%0d want=64", n); end
    ref_clear();
    access(0, 2'd2, 0, 8'h10, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL recleared_10 got=%h want=00000000", got); end
    access(0, 2'd2, 0, 8'h04, 0, got);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL ignored_req got=%h want=00000000", got); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_spec_vectors();
    test_back_to_back();
    test_wrap_align();
    test_random();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
